mem_arbiter: RTL

//  Shares the single byte-wide RAM/IO port between I-cache (read-only) and D-cache (read/write).

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_byte_engine.sv | 129 ++++++++++++
 rtl/mem_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the byte-serial memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_LAST = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_t;

    typedef enum logic {
        SRC_IC = 1'b0,
        SRC_DC = 1'b1
    } src_t;

    localparam logic [2:0] IC_LEN = 3'd4;

    // Anything that is not a byte or halfword access is a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_engine.sv
// rtl/mem_arbiter_byte_engine.sv - splits one granted access into per-byte RAM cycles and reassembles reads
module mem_byte_engine
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IO_BIT = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_buffer_full,
    input  logic              start,
    input  logic              start_write,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [2:0]        start_len,
    input  logic              start_signed,
    input  logic [DATA_W-1:0] start_data,
    output logic              idle,
    output logic              done,
    output logic [DATA_W-1:0] result,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    arb_state_t        state, state_nx;
    logic [2:0]        len_q;
    logic [2:0]        k;
    logic              sgn_q;
    logic              io_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_buf;
    logic              stall;
    logic              last_byte;
    logic [1:0]        cap_idx;
    logic [1:0]        nxt_idx;
    logic [1:0]        last_idx;
    logic [31:0]       cur;
    logic [DATA_W-1:0] ext;

    assign stall     = (state == ST_WR) && io_q && io_buffer_full;
    assign last_byte = (k == len_q - 3'd1);
    assign mem_wr    = (state == ST_WR) && !stall;
    assign idle      = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    // mem_din lags mem_a by one cycle, so the byte arriving now belongs to k-1.
    assign cap_idx   = k[1:0] - 2'd1;
    assign nxt_idx   = k[1:0] + 2'd1;
    assign last_idx  = len_q[1:0] - 2'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = start_write ? ST_WR : ST_RD;
            ST_RD:      if (last_byte) state_nx = ST_RD_LAST;
            ST_RD_LAST: state_nx = ST_DONE;
            ST_WR:      if (!stall && last_byte) state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Final read byte is merged straight from mem_din so the result is ready one cycle earlier.
    always_comb begin
        cur = rd_buf;
        cur[{last_idx, 3'b000} +: 8] = mem_din;
        ext = '0;
        case (len_q)
            3'd1: begin
                ext       = {DATA_W{sgn_q & cur[7]}};
                ext[7:0]  = cur[7:0];
            end
            3'd2: begin
                ext       = {DATA_W{sgn_q & cur[15]}};
                ext[15:0] = cur[15:0];
            end
            default: ext[31:0] = cur;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q    <= 3'd0;
            k        <= 3'd0;
            sgn_q    <= 1'b0;
            io_q     <= 1'b0;
            wdata_q  <= 32'd0;
            rd_buf   <= 32'd0;
            result   <= '0;
            mem_a    <= '0;
            mem_dout <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    len_q   <= start_len;
                    k       <= 3'd0;
                    sgn_q   <= start_signed;
                    io_q    <= start_addr[IO_BIT];
                    wdata_q <= start_data[31:0];
                    rd_buf  <= 32'd0;
                    result  <= '0;
                    mem_a   <= start_addr;
                    if (start_write) mem_dout <= start_data[7:0];
                end
                ST_RD: begin
                    if (k != 3'd0) rd_buf[{cap_idx, 3'b000} +: 8] <= mem_din;
                    k <= k + 3'd1;
                    if (!last_byte) mem_a <= mem_a + 1'b1;
                end
                ST_RD_LAST: result <= ext;
                ST_WR: if (!stall) begin
                    k <= k + 3'd1;
                    if (!last_byte) begin
                        mem_a    <= mem_a + 1'b1;
                        mem_dout <= wdata_q[{nxt_idx, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the byte-wide RAM/IO port between I-cache and D-cache (MEM_ARB_RR_EN: round-robin on collisions)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IO_BIT = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_buffer_full,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_busy,
    output logic              ic_ready,
    output logic [DATA_W-1:0] ic_data,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [2:0]        dc_length,
    input  logic              dc_signed,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_data_i,
    output logic              dc_busy,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_data_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    logic              dc_req;
    logic              grant_dc;
    logic              start;
    logic              eng_idle;
    logic              eng_done;
    logic [DATA_W-1:0] eng_result;
    src_t              grant_src;

    assign dc_req = dc_read | dc_write;
    assign start  = eng_idle && (ic_read || dc_req);

`ifdef MEM_ARB_RR_EN
    src_t last_grant;

    assign grant_dc = dc_req && (!ic_read || (last_grant == SRC_IC));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      last_grant <= SRC_IC;
        else if (start) last_grant <= grant_dc ? SRC_DC : SRC_IC;
    end
`else
    assign grant_dc = dc_req;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      grant_src <= SRC_IC;
        else if (start) grant_src <= grant_dc ? SRC_DC : SRC_IC;
    end

    mem_byte_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IO_BIT (IO_BIT)
    ) u_engine (
        .clock          (clock),
        .reset          (reset),
        .io_buffer_full (io_buffer_full),
        .start          (start),
        .start_write    (grant_dc && dc_write),
        .start_addr     (grant_dc ? dc_addr : ic_addr),
        .start_len      (grant_dc ? norm_len(dc_length) : IC_LEN),
        .start_signed   (grant_dc && dc_signed),
        .start_data     (dc_data_i),
        .idle           (eng_idle),
        .done           (eng_done),
        .result         (eng_result),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    // Both ports see the same busy so neither cache issues while the other is served.
    assign ic_busy   = ~eng_idle;
    assign dc_busy   = ~eng_idle;
    assign ic_ready  = eng_done && (grant_src == SRC_IC);
    assign dc_ready  = eng_done && (grant_src == SRC_DC);
    assign ic_data   = ic_ready ? eng_result : '0;
    assign dc_data_o = dc_ready ? eng_result : '0;

endmodule
